mac_pair_dp: RTL and testbench

Dual-lane multiply-accumulate datapath and controller that sits directly downstream of the address-generator stage of the 8×8 matrix-multiply engine. It drives `Load` into the address generator and consumes the resulting A/B memory read data, one k-step per cycle. Two lanes accumulate the dot products for C[i][j] and C[i][j+1] at the same time. Each finished pair is written to C memory through a single write port.

---
 rtl/matmul_pkg.sv | 25 ++
 rtl/mac_lane.sv | 50 +++++
 rtl/mac_pair_dp.sv | 148 ++++++++++++++
 tb/tb_mac_pair_dp.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing for the 8x8 matrix-multiply engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package matmul_pkg;

   localparam int N      = 8;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 2*DATA_W+3;   // holds the sum of N full-scale products
   localparam int ADDR_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } state_t;

   // Write-port phase after a result-pair capture.
   typedef enum logic [1:0] {
      W_NONE,
      W0,
      W1
   } wph_t;

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: unsigned multiply, 8-step accumulate, result register.
// Latency: result updates on the edge that consumes the last k-step.
// Backpressure: none; consumes a product on every v2 cycle.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   v2           - operands a/b are valid this cycle
//   first, last  - k-step 0 / k-step 7 of the current dot product
//   a, b         - unsigned operands
//   result       - last completed dot product, held until the next one
module mac_lane #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 2*DATA_W+3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              v2,
   input  logic              first,
   input  logic              last,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  result
);
   import matmul_pkg::*;

   logic [2*DATA_W-1:0] prod_full;
   logic [ACC_W-1:0]    prod;
   logic [ACC_W-1:0]    acc;
   logic [ACC_W-1:0]    sum;

   // Operands are widened first so the product keeps all 2*DATA_W bits.
   assign prod_full = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
   assign prod      = ACC_W'(prod_full);

   // k-step 0 loads instead of adding, so no separate clear cycle is needed.
   assign sum = first ? prod : acc + prod;

   always_ff @(posedge clk) begin
      if (reset) begin
         acc    <= '0;
         result <= '0;
      end else if (v2) begin
         acc <= sum;
         if (last) begin
            result <= sum;
         end
      end
   end

endmodule

// File: rtl/mac_pair_dp.sv
// Dual-lane MAC controller: drives Load, accumulates C[i][j] and C[i][j+1], writes pairs to C memory.
// Latency: read data 2 cycles after Load; a pair is written in the 2 cycles after its 8th k-step.
// Backpressure: none; 256 Load cycles back-to-back, writes overlap the next group's accumulation.
//
// Ports:
//   clk, reset              - clock, synchronous active-high reset (also resets the address generator)
//   start                   - run request, only looked at in IDLE
//   Load                    - advance enable to the address generator
//   dataA, dataB1, dataB2   - A row element, B column j / j+1 elements
//   weC, addrC, dataC       - C memory write port (addrC/dataC hold when weC=0)
//   busy, done              - running / finished status
module mac_pair_dp #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 2*DATA_W+3,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              Load,
   input  logic [DATA_W-1:0] dataA,
   input  logic [DATA_W-1:0] dataB1,
   input  logic [DATA_W-1:0] dataB2,
   output logic              weC,
   output logic [ADDR_W-1:0] addrC,
   output logic [ACC_W-1:0]  dataC,
   output logic              busy,
   output logic              done
);
   import matmul_pkg::*;

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       issue_cnt;
   logic             v1;
   logic             v2;
   logic [2:0]       kd;
   logic [4:0]       pi;
   logic [4:0]       pi_cap;
   wph_t             wph;
   logic             held_odd;
   logic             first;
   logic             last;
   logic             cap;
   logic             sel_odd;
   logic [ACC_W-1:0] r0;
   logic [ACC_W-1:0] r1;

   assign first = (kd == 3'd0);
   assign last  = (kd == 3'd7);
   assign cap   = v2 & last;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (issue_cnt == 8'd255) state_nxt = DRAIN;
         DRAIN:   if ((wph == W1) && (pi_cap == 5'd31)) state_nxt = DONE;
         DONE:    state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   assign Load = (state == RUN);
   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

   // ---------------- counters, valid pipe, write phase ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         issue_cnt <= '0;
         v1        <= 1'b0;
         v2        <= 1'b0;
         kd        <= '0;
         pi        <= '0;
         pi_cap    <= '0;
         wph       <= W_NONE;
         held_odd  <= 1'b0;
      end else begin
         if (Load) begin
            issue_cnt <= issue_cnt + 8'd1;
         end
         v1 <= Load;
         v2 <= v1;
         if (v2) begin
            kd <= kd + 3'd1;
         end
         if (cap) begin
            pi_cap <= pi;
            pi     <= pi + 5'd1;
         end
         if (cap) begin
            wph <= W0;
         end else if (wph == W0) begin
            wph <= W1;
         end else begin
            wph <= W_NONE;
         end
         // Remember which half was written last so the port holds it while idle.
         if (wph == W1) begin
            held_odd <= 1'b1;
         end else if (wph == W0) begin
            held_odd <= 1'b0;
         end
      end
   end

   // ---------------- lanes ----------------
   mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane0 (
      .clk    (clk),
      .reset  (reset),
      .v2     (v2),
      .first  (first),
      .last   (last),
      .a      (dataA),
      .b      (dataB1),
      .result (r0)
   );

   mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane1 (
      .clk    (clk),
      .reset  (reset),
      .v2     (v2),
      .first  (first),
      .last   (last),
      .a      (dataA),
      .b      (dataB2),
      .result (r1)
   );

   // ---------------- C write mux ----------------
   // Result registers and pi_cap only change on the capture edge, which is
   // also the edge that starts W0, so the idle port value never moves.
   assign sel_odd = (wph == W1) || ((wph == W_NONE) && held_odd);
   assign weC     = (wph != W_NONE);
   assign addrC   = ADDR_W'({pi_cap[4:2], pi_cap[1:0], sel_odd});
   assign dataC   = sel_odd ? r1 : r0;

endmodule

// File: tb/tb_mac_pair_dp.sv
// Bench for mac_pair_dp: models the address generator and A/B memories,
// computes the expected C matrix arithmetically and checks every cycle of each run.
module tb_mac_pair_dp;
   localparam int DATA_W = 8;
   localparam int ACC_W  = 2*DATA_W+3;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              Load;
   logic [DATA_W-1:0] dataA;
   logic [DATA_W-1:0] dataB1;
   logic [DATA_W-1:0] dataB2;
   logic              weC;
   logic [ADDR_W-1:0] addrC;
   logic [ACC_W-1:0]  dataC;
   logic              busy;
   logic              done;

   int n_assert = 0;
   int n_fail   = 0;

   int amat [8][8];
   int bmat [8][8];
   int cexp [64];
   bit seen [64];
   int ldq [$];
   int n_ld;

   always #5 clk = ~clk;

   mac_pair_dp #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .Load   (Load),
      .dataA  (dataA),
      .dataB1 (dataB1),
      .dataB2 (dataB2),
      .weC    (weC),
      .addrC  (addrC),
      .dataC  (dataC),
      .busy   (busy),
      .done   (done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // mode 0: A = identity, B[r][c] = r*8+c; mode 1: all 255; mode 2: random.
   task automatic fill(input int mode);
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            case (mode)
               0:       begin amat[r][c] = (r == c) ? 1 : 0; bmat[r][c] = r*8 + c; end
               1:       begin amat[r][c] = 255; bmat[r][c] = 255; end
               default: begin amat[r][c] = $urandom_range(255); bmat[r][c] = $urandom_range(255); end
            endcase
         end
      end
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            int s;
            s = 0;
            for (int k = 0; k < 8; k++) s += amat[r][k] * bmat[k][c];
            cexp[r*8 + c] = s;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      ldq.delete();
      n_ld = 0;
      repeat (2) @(negedge clk);
      chk("rst_load", Load, 0);
      chk("rst_wec", weC, 0);
      chk("rst_addrc", addrC, 0);
      chk("rst_datac", dataC, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      reset = 1'b0;
   endtask

   // Address generator + registered memory: load n reads A[i][k], B[k][j], B[k][j+1],
   // presented two cycles after its Load cycle.
   task automatic drive_data();
      int idx;
      ldq.push_back((Load === 1'b1) ? n_ld : -1);
      if (Load === 1'b1) n_ld++;
      idx = (ldq.size() == 3) ? ldq.pop_front() : -1;
      if (idx >= 0) begin
         int g, k, i, j;
         g = idx / 8;
         k = idx % 8;
         i = g / 4;
         j = (g % 4) * 2;
         dataA  = 8'(amat[i][k]);
         dataB1 = 8'(bmat[k][j]);
         dataB2 = 8'(bmat[k][j+1]);
      end else begin
         dataA  = 8'($urandom);
         dataB1 = 8'($urandom);
         dataB2 = 8'($urandom);
      end
   endtask

   // smode 0: one-cycle start pulse; 1: start held high; 2: random start during run.
   task automatic run(input int abort_at, input int smode);
      int nwr;
      int last_addr;
      int last_data;
      nwr       = 0;
      last_addr = 0;
      last_data = 0;
      for (int a = 0; a < 64; a++) seen[a] = 1'b0;
      start = 1'b1;
      @(negedge clk);
      for (int cyc = 0; cyc < 270; cyc++) begin
         int  rel;
         bit  expw;
         rel  = cyc - 10;
         expw = (cyc >= 10) && (cyc <= 259) && ((rel % 8) < 2);
         chk("load", Load, (cyc <= 255));
         chk("busy", busy, (cyc <= 259));
         chk("done", done, (cyc >= 260));
         chk("wec", weC, expw);
         if (expw) begin
            int g, ea;
            g  = rel / 8;
            ea = (g / 4) * 8 + (g % 4) * 2 + (rel % 8);
            chk("addrc", addrC, ea);
            chk("datac", dataC, cexp[ea]);
            last_addr = ea;
            last_data = cexp[ea];
         end else begin
            chk("hold_addrc", addrC, last_addr);
            chk("hold_datac", dataC, last_data);
         end
         if (weC === 1'b1 && addrC < 64) begin
            chk("dup_write", seen[addrC], 0);
            seen[addrC] = 1'b1;
            nwr++;
         end
         if (cyc == abort_at) begin
            reset = 1'b1;
            @(negedge clk);
            chk("abort_load", Load, 0);
            chk("abort_wec", weC, 0);
            chk("abort_done", done, 0);
            chk("abort_busy", busy, 0);
            reset = 1'b0;
            start = 1'b0;
            ldq.delete();
            n_ld = 0;
            return;
         end
         drive_data();
         case (smode)
            0:       start = 1'b0;
            1:       start = 1'b1;
            default: start = (cyc < 256) ? 1'($urandom) : 1'b0;
         endcase
         @(negedge clk);
      end
      chk("nwrites", nwr, 64);
      start = 1'b0;
   endtask

   initial begin
      reset  = 1'b1;
      start  = 1'b0;
      dataA  = '0;
      dataB1 = '0;
      dataB2 = '0;
      n_ld   = 0;

      // identity x index pattern
      do_reset();
      fill(0);
      run(-1, 0);

      // full-scale operands, no wrap
      do_reset();
      fill(1);
      run(-1, 0);

      // reset mid-run, then a fresh full run
      do_reset();
      fill(2);
      run(100, 0);
      fill(2);
      run(-1, 0);

      // start held high throughout
      do_reset();
      fill(2);
      run(-1, 1);

      // random start toggling while running
      do_reset();
      fill(2);
      run(-1, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
